// File: rtl/ntt_pkg.sv
// Shared NTT constants and types for the modular-domain converter.
// The mo_domain_conv top and its mo_conv_step stage import this package.
package ntt_pkg;

  localparam int DATA_WIDTH = 12;
  localparam logic [DATA_WIDTH-1:0] Q = 12'd3329;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_RUN,
    CONV_DONE
  } conv_state_e;

  typedef enum logic {
    CONV_TO,
    CONV_FROM
  } conv_dir_e;

endpackage

// File: rtl/mo_conv_step.sv
// One combinational modular step: doubling (into domain) or halving (out of domain) mod Q.
// Inputs are expected canonical (< Q); the output is then canonical as well.
module mo_conv_step
  import ntt_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] x,
  input  conv_dir_e             dir,
  output logic [DATA_WIDTH-1:0] x_next
);

  localparam logic [DATA_WIDTH:0] QE = {1'b0, Q};

  function automatic logic [DATA_WIDTH-1:0] mod_dbl(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH:0] y;
    y = {v, 1'b0};
    y = (y >= QE) ? y - QE : y;
    return y[DATA_WIDTH-1:0];
  endfunction

  // Q is odd, so adding Q to an odd value makes it even and the halving is exact.
  function automatic logic [DATA_WIDTH-1:0] mod_half(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH:0] y;
    y = v[0] ? {1'b0, v} + QE : {1'b0, v};
    y = y >> 1;
    return y[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    x_next = (dir == CONV_FROM) ? mod_half(x) : mod_dbl(x);
  end

endmodule

// File: rtl/mo_domain_conv.sv
// Iterative shift/add/subtract converter: x*2^SHIFTS mod Q or x*2^-SHIFTS mod Q.
// Optional MO_CONV_CHK_EN adds the sticky range_err flag for inputs above Q.
module mo_domain_conv
  import ntt_pkg::*;
#(
  parameter int SHIFTS    = DATA_WIDTH,
  parameter int STEPS_PER = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
`ifdef MO_CONV_CHK_EN
  ,
  output logic                  range_err
`endif
);

  localparam int CW = $clog2(SHIFTS + 1);
  localparam logic [CW-1:0] STEP_INC = CW'(STEPS_PER);
  localparam logic [CW-1:0] CNT_LAST = CW'(SHIFTS - STEPS_PER);

  conv_state_e           state, state_nxt;
  conv_dir_e             dir_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  accept;
  logic [DATA_WIDTH-1:0] chain [0:STEPS_PER];

  assign chain[0] = x_q;

  for (genvar g = 0; g < STEPS_PER; g++) begin : g_step
    mo_conv_step u_step (
      .x      (chain[g]),
      .dir    (dir_q),
      .x_next (chain[g+1])
    );
  end

  // A single conditional subtract maps 0..Q (and anything below 2Q) to canonical form.
  assign load_val  = (in_data >= Q) ? in_data - Q : in_data;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == CONV_DONE);
  assign busy      = (state != CONV_IDLE);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      CONV_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV_RUN;
      end
      CONV_RUN: begin
        if (cnt_q == CNT_LAST) state_nxt = CONV_DONE;
      end
      CONV_DONE: begin
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? CONV_RUN : CONV_IDLE;
        end
      end
      default: state_nxt = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CONV_IDLE;
      dir_q    <= CONV_TO;
      x_q      <= '0;
      cnt_q    <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q   <= load_val;
        dir_q <= conv_dir_e'(in_dir);
        cnt_q <= '0;
      end else if (state == CONV_RUN) begin
        x_q   <= chain[STEPS_PER];
        cnt_q <= cnt_q + STEP_INC;
        if (cnt_q == CNT_LAST) out_data <= chain[STEPS_PER];
      end
    end
  end

`ifdef MO_CONV_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (accept && (in_data > Q)) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule
